decode_dispatch_queue: RTL and testbench
========================================

// Module: decode_dispatch_queue
// PURPOSE
//  In-order operand-capture queue directly downstream of the decode register/rename stage.
//  Accepts one decoded uop per cycle with regfile operands and RAT source tags.
//  Pending sources snoop the writeback bus for their ROB tag and capture the value.
//  The head uop is presented to issue only when both operands are resolved. Branch-commit override flushes the queue.
// PARAMETERS
//  DEPTH   4    queue entries; power of 2, >=2
//  UOP_W   32   opaque decoded-uop payload width, carried untouched
// PORTS
//  clk               in   1      clock, all state on rising edge
//  resetn            in   1      asynchronous active-low reset
//  bco_valid         in   1      branch-commit override: flush all entries
//  i_valid           in   1      upstream uop valid
//  o_ready           out  1      queue can accept (not full)
//  i_uop             in   UOP_W  decoded uop payload
//  i_dst_rob         in   4      ROB entry allocated to this uop
//  i_regfs_data0/1   in   32     regfile read values, src0/src1
//  i_rat_src0/1_valid in  1      1 = source renamed in flight; wait on tag
//  i_rat_src0/1_rob  in   4      ROB tag producing the source
//  wb_valid          in   1      writeback bus valid
//  wb_rob            in   4      writeback ROB tag
//  wb_data           in   32     writeback value
//  o_valid           out  1      head uop valid, both operands ready
//  i_ready           in   1      issue accepts head
//  o_uop             out  UOP_W  head payload
//  o_dst_rob         out  4      head destination ROB tag
//  o_src0/1_data     out  32     head resolved operands
//  o_count           out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async): rd/wr ptr=0, count=0, all entry valid/ready/data/tag/uop=0; so o_valid=0, o_ready=1, outputs 0.
//  - Entry: valid, uop, dst_rob, per source {rdy, tag[3:0], data[31:0]}. Circular; ptrs wrap DEPTH-1 -> 0.
//  - o_ready = (count != DEPTH). Depends only on registered count; no credit for a same-cycle dequeue.
//  - Enqueue when i_valid && o_ready: src rat_valid=0 -> rdy=1, data=regfs_data.
//    rat_valid=1 -> rdy=0, tag=rob, unless wb_valid && wb_rob==rob that cycle -> rdy=1, data=wb_data (enqueue bypass).
//  - Wakeup: every cycle, each valid entry, each source with rdy=0 and wb_valid && wb_rob==tag sets rdy=1, data=wb_data.
//    One wb matches every waiting source at once, incl. both sources of one entry.
//  - o_valid = head.valid && head.src0.rdy && head.src1.rdy; outputs read combinationally from registered head entry.
//  - No same-cycle pass-through: data enqueued or woken at edge t drives o_valid from cycle t+1. A wb in the same cycle as a
//    head stall does not assert o_valid until the next cycle.
//  - Dequeue when o_valid && i_ready: clear head.valid, rd_ptr++. Enqueue+dequeue same cycle: count unchanged.
//  - Non-head entries may be ready; issue is strictly in order (head only).
//  - bco_valid=1: at next edge all entries invalid, ptrs=0, count=0.
//    Wins over enqueue, dequeue and wakeup that cycle. Upstream must drop the offered uop. o_valid may be high during the flush
//    cycle; issue ignores any handshake in a bco cycle.
//  - Empty: o_valid=0, outputs hold stale storage (don't-care).
//  - Full: o_ready=0 even if head dequeues that cycle.
//  - Tag 0 is a legal ROB tag; rdy, never tag value, marks resolution.
// TESTING
//  1 Enq src0/src1 regfile-ready (0x11,0x22), i_ready=1 -> o_valid next cycle, o_src0=0x11, o_src1=0x22, o_count 1->0.
//  2 Enq src0 waiting rob 5; wb rob5=0xABCD two cycles later -> o_valid rises the cycle after wb, o_src0=0xABCD.
//  3 Enq with src1 tag 3 while wb_valid rob3=0x77 same cycle -> captured via bypass, o_valid next cycle, o_src1=0x77.
//  4 Fill DEPTH=4 with i_ready=0 -> o_ready=0 at count 4; one dequeue -> o_ready=1 next cycle.
//    Wrap: 10 enq/deq, all in order.
//  5 Head waits rob2 and entry1 ready -> o_valid stays 0 (in-order). wb rob2 -> head issues, then entry1 next cycle.
//  6 Count 3 with bco_valid, i_valid and wb in same cycle -> count 0, o_valid 0, o_ready 1 next cycle.
//    Assert resetn low mid-stream -> async clear, same state.

Source files
------------

// File: rtl/decode_dispatch_queue_if.sv
// Bundle of the decode-to-issue queue signals: upstream enqueue, writeback snoop,
// flush and the issue-side head handshake.
interface decode_dispatch_queue_if #(
  parameter int UOP_W = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             bco_valid;
  logic             i_valid;
  logic             o_ready;
  logic [UOP_W-1:0] i_uop;
  logic [3:0]       i_dst_rob;
  logic [31:0]      i_regfs_data0;
  logic [31:0]      i_regfs_data1;
  logic             i_rat_src0_valid;
  logic             i_rat_src1_valid;
  logic [3:0]       i_rat_src0_rob;
  logic [3:0]       i_rat_src1_rob;
  logic             wb_valid;
  logic [3:0]       wb_rob;
  logic [31:0]      wb_data;
  logic             o_valid;
  logic             i_ready;
  logic [UOP_W-1:0] o_uop;
  logic [3:0]       o_dst_rob;
  logic [31:0]      o_src0_data;
  logic [31:0]      o_src1_data;
  logic [CW-1:0]    o_count;

  modport master (
    output bco_valid, i_valid, i_uop, i_dst_rob, i_regfs_data0, i_regfs_data1,
           i_rat_src0_valid, i_rat_src1_valid, i_rat_src0_rob, i_rat_src1_rob,
           wb_valid, wb_rob, wb_data, i_ready,
    input  o_ready, o_valid, o_uop, o_dst_rob, o_src0_data, o_src1_data, o_count
  );

  modport slave (
    input  bco_valid, i_valid, i_uop, i_dst_rob, i_regfs_data0, i_regfs_data1,
           i_rat_src0_valid, i_rat_src1_valid, i_rat_src0_rob, i_rat_src1_rob,
           wb_valid, wb_rob, wb_data, i_ready,
    output o_ready, o_valid, o_uop, o_dst_rob, o_src0_data, o_src1_data, o_count
  );
endinterface

// File: rtl/decode_dispatch_queue.sv
// In-order operand-capture queue: uops wait here until both sources are resolved,
// snooping the writeback bus, and issue strictly from the head.
module decode_dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int UOP_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  decode_dispatch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_valid;
  logic [UOP_W-1:0] r_uop   [DEPTH];
  logic [3:0]       r_dst   [DEPTH];
  logic [DEPTH-1:0] r_rdy0;
  logic [DEPTH-1:0] r_rdy1;
  logic [3:0]       r_tag0  [DEPTH];
  logic [3:0]       r_tag1  [DEPTH];
  logic [31:0]      r_data0 [DEPTH];
  logic [31:0]      r_data1 [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_enq;
  logic             w_deq;
  logic             w_enq_rdy0;
  logic             w_enq_rdy1;
  logic [31:0]      w_enq_data0;
  logic [31:0]      w_enq_data1;
  logic [DEPTH-1:0] w_hit0;
  logic [DEPTH-1:0] w_hit1;

  // Full is judged on the registered count only; a same-cycle dequeue earns no credit.
  assign bus.o_ready     = (r_count != CW'(DEPTH));
  assign bus.o_valid     = r_valid[r_rd_ptr] && r_rdy0[r_rd_ptr] && r_rdy1[r_rd_ptr];
  assign bus.o_uop       = r_uop[r_rd_ptr];
  assign bus.o_dst_rob   = r_dst[r_rd_ptr];
  assign bus.o_src0_data = r_data0[r_rd_ptr];
  assign bus.o_src1_data = r_data1[r_rd_ptr];
  assign bus.o_count     = r_count;

  assign w_enq = bus.i_valid && bus.o_ready;
  assign w_deq = bus.o_valid && bus.i_ready;

  // A source renamed to a tag being written back this very cycle is captured on entry.
  assign w_enq_rdy0  = !bus.i_rat_src0_valid || (bus.wb_valid && bus.wb_rob == bus.i_rat_src0_rob);
  assign w_enq_rdy1  = !bus.i_rat_src1_valid || (bus.wb_valid && bus.wb_rob == bus.i_rat_src1_rob);
  assign w_enq_data0 = bus.i_rat_src0_valid ? bus.wb_data : bus.i_regfs_data0;
  assign w_enq_data1 = bus.i_rat_src1_valid ? bus.wb_data : bus.i_regfs_data1;

  always_comb begin
    w_hit0 = '0;
    w_hit1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit0[i] = r_valid[i] && !r_rdy0[i] && bus.wb_valid && (bus.wb_rob == r_tag0[i]);
      w_hit1[i] = r_valid[i] && !r_rdy1[i] && bus.wb_valid && (bus.wb_rob == r_tag1[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= '0;
      r_rdy0   <= '0;
      r_rdy1   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_uop[i]   <= '0;
        r_dst[i]   <= '0;
        r_tag0[i]  <= '0;
        r_tag1[i]  <= '0;
        r_data0[i] <= '0;
        r_data1[i] <= '0;
      end
    end else if (bus.bco_valid) begin
      r_valid  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hit0[i]) begin
          r_rdy0[i]  <= 1'b1;
          r_data0[i] <= bus.wb_data;
        end
        if (w_hit1[i]) begin
          r_rdy1[i]  <= 1'b1;
          r_data1[i] <= bus.wb_data;
        end
      end
      if (w_deq) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      // The write slot is never a valid entry here, so it cannot collide with a wakeup.
      if (w_enq) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_uop[r_wr_ptr]   <= bus.i_uop;
        r_dst[r_wr_ptr]   <= bus.i_dst_rob;
        r_rdy0[r_wr_ptr]  <= w_enq_rdy0;
        r_rdy1[r_wr_ptr]  <= w_enq_rdy1;
        r_tag0[r_wr_ptr]  <= bus.i_rat_src0_rob;
        r_tag1[r_wr_ptr]  <= bus.i_rat_src1_rob;
        r_data0[r_wr_ptr] <= w_enq_data0;
        r_data1[r_wr_ptr] <= w_enq_data1;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CW'(1);
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed testbench for decode_dispatch_queue: each scenario task drives vectors
// and checks hand-computed results one cycle at a time.
module tb_decode_dispatch_queue;
  logic clk;
  logic resetn;
  int   passCount;
  int   checkCount;

  decode_dispatch_queue_if #(.UOP_W(32), .DEPTH(4)) bus ();

  decode_dispatch_queue #(.DEPTH(4), .UOP_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.bco_valid        = 1'b0;
    bus.i_valid          = 1'b0;
    bus.i_uop            = '0;
    bus.i_dst_rob        = '0;
    bus.i_regfs_data0    = '0;
    bus.i_regfs_data1    = '0;
    bus.i_rat_src0_valid = 1'b0;
    bus.i_rat_src1_valid = 1'b0;
    bus.i_rat_src0_rob   = '0;
    bus.i_rat_src1_rob   = '0;
    bus.wb_valid         = 1'b0;
    bus.wb_rob           = '0;
    bus.wb_data          = '0;
    bus.i_ready          = 1'b0;
  endtask

  task automatic drive_enq(input logic [31:0] uop, input logic [3:0] dst,
                           input logic [31:0] d0, input logic v0, input logic [3:0] t0,
                           input logic [31:0] d1, input logic v1, input logic [3:0] t1);
    bus.i_valid          = 1'b1;
    bus.i_uop            = uop;
    bus.i_dst_rob        = dst;
    bus.i_regfs_data0    = d0;
    bus.i_rat_src0_valid = v0;
    bus.i_rat_src0_rob   = t0;
    bus.i_regfs_data1    = d1;
    bus.i_rat_src1_valid = v1;
    bus.i_rat_src1_rob   = t1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #12;
    checkCount++;
    if (bus.o_valid !== 1'b0) $display("[TB] FAIL reset_o_valid: got %0b expected 0", bus.o_valid);
    else passCount++;
    checkCount++;
    if (bus.o_ready !== 1'b1) $display("[TB] FAIL reset_o_ready: got %0b expected 1", bus.o_ready);
    else passCount++;
    checkCount++;
    if (bus.o_count !== 3'd0) $display("[TB] FAIL reset_o_count: got %0d expected 0", bus.o_count);
    else passCount++;
    checkCount++;
    if (bus.o_uop !== 32'h0 || bus.o_src0_data !== 32'h0 || bus.o_src1_data !== 32'h0)
      $display("[TB] FAIL reset_outputs: got uop %h src0 %h src1 %h expected all 0",
               bus.o_uop, bus.o_src0_data, bus.o_src1_data);
    else passCount++;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.i_ready = 1'b1;
    drive_enq(32'h100, 4'd1, 32'h11, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0);
    checkCount++;
    if (bus.o_valid !== 1'b0) $display("[TB] FAIL basic_no_passthrough: got %0b expected 0", bus.o_valid);
    else passCount++;
    tick();
    bus.i_valid = 1'b0;
    checkCount++;
    if (bus.o_valid !== 1'b1 || bus.o_src0_data !== 32'h11 || bus.o_src1_data !== 32'h22 ||
        bus.o_uop !== 32'h100 || bus.o_dst_rob !== 4'd1 || bus.o_count !== 3'd1)
      $display("[TB] FAIL basic_head: got v%0b s0 %h s1 %h uop %h dst %0d cnt %0d expected v1 s0 11 s1 22 uop 100 dst 1 cnt 1",
               bus.o_valid, bus.o_src0_data, bus.o_src1_data, bus.o_uop, bus.o_dst_rob, bus.o_count);
    else passCount++;
    tick();
    checkCount++;
    if (bus.o_count !== 3'd0 || bus.o_valid !== 1'b0)
      $display("[TB] FAIL basic_drained: got cnt %0d v%0b expected cnt 0 v0", bus.o_count, bus.o_valid);
    else passCount++;
    idle_inputs();
  endtask

  task automatic test_wakeup();
    bus.i_ready = 1'b1;
    drive_enq(32'h200, 4'd6, 32'hDEAD, 1'b1, 4'd5, 32'h33, 1'b0, 4'd0);
    tick();
    bus.i_valid = 1'b0;
    checkCount++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd1)
      $display("[TB] FAIL wakeup_waiting: got v%0b cnt %0d expected v0 cnt 1", bus.o_valid, bus.o_count);
    else passCount++;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rob   = 4'd5;
    bus.wb_data  = 32'hABCD;
    checkCount++;
    if (bus.o_valid !== 1'b0) $display("[TB] FAIL wakeup_same_cycle: got %0b expected 0", bus.o_valid);
    else passCount++;
    tick();
    bus.wb_valid = 1'b0;
    checkCount++;
    if (bus.o_valid !== 1'b1 || bus.o_src0_data !== 32'hABCD || bus.o_src1_data !== 32'h33)
      $display("[TB] FAIL wakeup_issue: got v%0b s0 %h s1 %h expected v1 s0 abcd s1 33",
               bus.o_valid, bus.o_src0_data, bus.o_src1_data);
    else passCount++;
    tick();
    idle_inputs();
  endtask

  task automatic test_bypass();
    bus.i_ready  = 1'b1;
    drive_enq(32'h300, 4'd7, 32'h44, 1'b0, 4'd0, 32'hBEEF, 1'b1, 4'd3);
    bus.wb_valid = 1'b1;
    bus.wb_rob   = 4'd3;
    bus.wb_data  = 32'h77;
    tick();
    idle_inputs();
    bus.i_ready = 1'b1;
    checkCount++;
    if (bus.o_valid !== 1'b1 || bus.o_src1_data !== 32'h77 || bus.o_src0_data !== 32'h44)
      $display("[TB] FAIL bypass_issue: got v%0b s0 %h s1 %h expected v1 s0 44 s1 77",
               bus.o_valid, bus.o_src0_data, bus.o_src1_data);
    else passCount++;
    tick();
    idle_inputs();
  endtask

  task automatic test_full_and_wrap();
    int errs;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_enq(32'h400 + k, 4'(k), 32'h1000 + k, 1'b0, 4'd0, 32'h2000 + k, 1'b0, 4'd0);
      tick();
    end
    idle_inputs();
    checkCount++;
    if (bus.o_count !== 3'd4 || bus.o_ready !== 1'b0)
      $display("[TB] FAIL full_state: got cnt %0d rdy %0b expected cnt 4 rdy 0", bus.o_count, bus.o_ready);
    else passCount++;
    drive_enq(32'hBAD, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    bus.i_ready = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    checkCount++;
    if (bus.o_count !== 3'd3 || bus.o_ready !== 1'b1 || bus.o_uop !== 32'h401)
      $display("[TB] FAIL full_deq: got cnt %0d rdy %0b uop %h expected cnt 3 rdy 1 uop 401",
               bus.o_count, bus.o_ready, bus.o_uop);
    else passCount++;
    errs = 0;
    bus.i_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      if (bus.o_valid !== 1'b1 || bus.o_uop !== 32'h400 + k || bus.o_src1_data !== 32'h2000 + k) errs++;
      tick();
    end
    checkCount++;
    if (errs !== 0 || bus.o_count !== 3'd0)
      $display("[TB] FAIL full_drain_order: got %0d bad heads cnt %0d expected 0 bad cnt 0", errs, bus.o_count);
    else passCount++;
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      drive_enq(32'h500 + k, 4'(k), 32'h3000 + k, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
      if (k > 0 && (bus.o_valid !== 1'b1 || bus.o_uop !== 32'h500 + k - 1 || bus.o_src0_data !== 32'h3000 + k - 1)) errs++;
      tick();
    end
    bus.i_valid = 1'b0;
    checkCount++;
    if (errs !== 0 || bus.o_valid !== 1'b1 || bus.o_uop !== 32'h509 || bus.o_count !== 3'd1)
      $display("[TB] FAIL wrap_order: got %0d bad heads uop %h cnt %0d expected 0 bad uop 509 cnt 1",
               errs, bus.o_uop, bus.o_count);
    else passCount++;
    tick();
    idle_inputs();
  endtask

  task automatic test_in_order();
    bus.i_ready = 1'b1;
    drive_enq(32'h600, 4'd10, 32'h0, 1'b1, 4'd2, 32'h88, 1'b0, 4'd0);
    tick();
    drive_enq(32'h601, 4'd11, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0);
    tick();
    bus.i_valid = 1'b0;
    checkCount++;
    if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd2)
      $display("[TB] FAIL inorder_blocked: got v%0b cnt %0d expected v0 cnt 2", bus.o_valid, bus.o_count);
    else passCount++;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rob   = 4'd2;
    bus.wb_data  = 32'h99;
    tick();
    bus.wb_valid = 1'b0;
    checkCount++;
    if (bus.o_valid !== 1'b1 || bus.o_uop !== 32'h600 || bus.o_src0_data !== 32'h99)
      $display("[TB] FAIL inorder_head: got v%0b uop %h s0 %h expected v1 uop 600 s0 99",
               bus.o_valid, bus.o_uop, bus.o_src0_data);
    else passCount++;
    tick();
    checkCount++;
    if (bus.o_valid !== 1'b1 || bus.o_uop !== 32'h601 || bus.o_src0_data !== 32'h55)
      $display("[TB] FAIL inorder_second: got v%0b uop %h s0 %h expected v1 uop 601 s0 55",
               bus.o_valid, bus.o_uop, bus.o_src0_data);
    else passCount++;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_and_async_reset();
    bus.i_ready = 1'b0;
    drive_enq(32'h700, 4'd1, 32'h1, 1'b0, 4'd0, 32'h2, 1'b0, 4'd0);
    tick();
    drive_enq(32'h701, 4'd2, 32'h3, 1'b1, 4'd7, 32'h4, 1'b0, 4'd0);
    tick();
    drive_enq(32'h702, 4'd3, 32'h5, 1'b0, 4'd0, 32'h6, 1'b0, 4'd0);
    tick();
    checkCount++;
    if (bus.o_count !== 3'd3) $display("[TB] FAIL flush_precount: got %0d expected 3", bus.o_count);
    else passCount++;
    drive_enq(32'h703, 4'd4, 32'h7, 1'b0, 4'd0, 32'h8, 1'b0, 4'd0);
    bus.bco_valid = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rob    = 4'd7;
    bus.wb_data   = 32'h123;
    tick();
    idle_inputs();
    checkCount++;
    if (bus.o_count !== 3'd0 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1)
      $display("[TB] FAIL flush_state: got cnt %0d v%0b rdy %0b expected cnt 0 v0 rdy 1",
               bus.o_count, bus.o_valid, bus.o_ready);
    else passCount++;
    drive_enq(32'h710, 4'd5, 32'hA, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0);
    tick();
    tick();
    bus.i_valid = 1'b0;
    checkCount++;
    if (bus.o_count !== 3'd2 || bus.o_uop !== 32'h710)
      $display("[TB] FAIL reset_prestate: got cnt %0d uop %h expected cnt 2 uop 710", bus.o_count, bus.o_uop);
    else passCount++;
    #2;
    resetn = 1'b0;
    #1;
    checkCount++;
    if (bus.o_count !== 3'd0 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1)
      $display("[TB] FAIL async_reset: got cnt %0d v%0b rdy %0b expected cnt 0 v0 rdy 1",
               bus.o_count, bus.o_valid, bus.o_ready);
    else passCount++;
    tick();
    resetn = 1'b1;
    bus.i_ready = 1'b1;
    drive_enq(32'h720, 4'd0, 32'h0, 1'b1, 4'd0, 32'hC, 1'b0, 4'd0);
    tick();
    bus.i_valid  = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_rob   = 4'd0;
    bus.wb_data  = 32'h5A5A;
    tick();
    bus.wb_valid = 1'b0;
    checkCount++;
    if (bus.o_valid !== 1'b1 || bus.o_uop !== 32'h720 || bus.o_src0_data !== 32'h5A5A)
      $display("[TB] FAIL tag0_wakeup: got v%0b uop %h s0 %h expected v1 uop 720 s0 5a5a",
               bus.o_valid, bus.o_uop, bus.o_src0_data);
    else passCount++;
    tick();
    idle_inputs();
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    resetn     = 1'b1;
    idle_inputs();
    #3;
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_and_wrap();
    test_in_order();
    test_flush_and_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
